// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the five-stage pipeline sequencer.
// Holds the sequencer state enum, wait-counter width and the pipeline control bundle.
package pipe_ctrl_pkg;

  localparam int WAIT_CNT_W = 8;
  localparam logic [4:0] ZERO_REG = 5'd0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } ctrlState_e;

  typedef struct packed {
    logic pcWrite;
    logic ifIdWrite;
    logic idExWrite;
    logic exMemWrite;
    logic ifIdFlush;
    logic idExFlush;
    logic exMemFlush;
    logic memWbFlush;
    logic pcSelRedirect;
  } pipeCtrl_t;

  // Everything advances normally; the bubble freeze holds all stages and drains MEM/WB.
  localparam pipeCtrl_t CTRL_ADVANCE = pipeCtrl_t'(9'b1111_0000_0);
  localparam pipeCtrl_t CTRL_FREEZE  = pipeCtrl_t'(9'b0000_0001_0);

  // Normal-flow decision: a redirect squashes the younger slots and outranks load-use.
  function automatic pipeCtrl_t runCtrl(input logic redirect, input logic loadUse);
    pipeCtrl_t c;
    c = CTRL_ADVANCE;
    if (redirect) begin
      c.pcSelRedirect = 1'b1;
      c.ifIdFlush     = 1'b1;
      c.idExFlush     = 1'b1;
      c.exMemFlush    = 1'b1;
    end else if (loadUse) begin
      c.pcWrite   = 1'b0;
      c.ifIdWrite = 1'b0;
      c.idExFlush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-observation inputs and pipeline-register controls between datapath and sequencer.
interface pipe_hazard_ctrl_if;

  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       id_uses_rt;
  logic       ex_memread;
  logic [4:0] ex_writereg;
  logic       mem_redirect;
  logic       mem_access;
  logic       dmem_ready;

  logic       pc_write;
  logic       if_id_write;
  logic       id_ex_write;
  logic       ex_mem_write;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       ex_mem_flush;
  logic       mem_wb_flush;
  logic       pc_sel_redirect;

  modport master (
    output id_rs, id_rt, id_uses_rt, ex_memread, ex_writereg,
           mem_redirect, mem_access, dmem_ready,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel_redirect
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, ex_memread, ex_writereg,
           mem_redirect, mem_access, dmem_ready,
    output pc_write, if_id_write, id_ex_write, ex_mem_write,
           if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, pc_sel_redirect
  );

endinterface

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Combinational load-use compare between the load in EX and the source registers in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] idRs,
  input  logic [4:0] idRt,
  input  logic       idUsesRt,
  input  logic       exMemRead,
  input  logic [4:0] exWriteReg,
  output logic       loadUse
);

  // $zero is hardwired, so a load targeting it never creates a real dependency.
  assign loadUse = exMemRead && (exWriteReg != ZERO_REG) &&
                   ((exWriteReg == idRs) || (idUsesRt && (exWriteReg == idRt)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: load-use stalls, MEM-stage redirects and data-memory waits with timeout.
// Define HAZARD_PERF_CNT_EN to add the stall/wait/flush performance counters.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                clk_i,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   hzd,
  output logic                err_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         stall_cycles_o,
  output logic [31:0]         wait_cycles_o,
  output logic [31:0]         flush_events_o
`endif
);

  localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(TIMEOUT);

  ctrlState_e            state;
  ctrlState_e            nextState;
  logic [WAIT_CNT_W-1:0] waitCnt;
  logic [WAIT_CNT_W-1:0] nextWaitCnt;
  logic                  freezeNow;
  logic                  memWait;
  logic                  loadUse;
  pipeCtrl_t             ctrl;

  hazard_detect uHazardDetect (
    .idRs      (hzd.id_rs),
    .idRt      (hzd.id_rt),
    .idUsesRt  (hzd.id_uses_rt),
    .exMemRead (hzd.ex_memread),
    .exWriteReg(hzd.ex_writereg),
    .loadUse   (loadUse)
  );

  assign memWait = hzd.mem_access && !hzd.dmem_ready;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      waitCnt <= '0;
    end else begin
      state   <= nextState;
      waitCnt <= nextWaitCnt;
    end
  end

  // A wait holds regardless of mem_access; only dmem_ready releases it, and the
  // release cycle falls through to the normal redirect/load-use evaluation.
  always_comb begin
    nextState   = state;
    nextWaitCnt = waitCnt;
    freezeNow   = 1'b0;
    case (state)
      RUN: begin
        if (memWait) begin
          freezeNow   = 1'b1;
          nextState   = MEM_WAIT;
          nextWaitCnt = WAIT_CNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (hzd.dmem_ready) begin
          nextState   = RUN;
          nextWaitCnt = '0;
        end else begin
          freezeNow = 1'b1;
          if (waitCnt == TIMEOUT_CNT) begin
            nextState = ERR;
          end else begin
            nextWaitCnt = waitCnt + 1'b1;
          end
        end
      end
      ERR: begin
        freezeNow = 1'b1;
      end
      default: begin
        nextState   = RUN;
        nextWaitCnt = '0;
      end
    endcase
  end

  assign ctrl = freezeNow ? CTRL_FREEZE : runCtrl(hzd.mem_redirect, loadUse);

  assign hzd.pc_write        = ctrl.pcWrite;
  assign hzd.if_id_write     = ctrl.ifIdWrite;
  assign hzd.id_ex_write     = ctrl.idExWrite;
  assign hzd.ex_mem_write    = ctrl.exMemWrite;
  assign hzd.if_id_flush     = ctrl.ifIdFlush;
  assign hzd.id_ex_flush     = ctrl.idExFlush;
  assign hzd.ex_mem_flush    = ctrl.exMemFlush;
  assign hzd.mem_wb_flush    = ctrl.memWbFlush;
  assign hzd.pc_sel_redirect = ctrl.pcSelRedirect;
  assign err_o               = (state == ERR);

`ifdef HAZARD_PERF_CNT_EN
  logic stallCycle;
  logic waitCycle;
  logic flushCycle;

  assign stallCycle = !freezeNow && !hzd.mem_redirect && loadUse;
  assign waitCycle  = freezeNow && (state != ERR);
  assign flushCycle = !freezeNow && hzd.mem_redirect;

  // Free-running wrapping counters, one increment per affected cycle.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_o <= '0;
      wait_cycles_o  <= '0;
      flush_events_o <= '0;
    end else begin
      if (stallCycle) stall_cycles_o <= stall_cycles_o + 32'd1;
      if (waitCycle)  wait_cycles_o  <= wait_cycles_o + 32'd1;
      if (flushCycle) flush_events_o <= flush_events_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios plus randomized traffic
// compared against a cycle-level reference model of the sequencing rules.
module tb_pipe_hazard_ctrl;

  localparam int TIMEOUT_TB = 4;

  // Output vector order: pcW ifIdW idExW exMemW | ifIdF idExF exMemF memWbF | pcSel | err
  localparam logic [9:0] EXP_IDLE     = 10'b1111_0000_0_0;
  localparam logic [9:0] EXP_FREEZE   = 10'b0000_0001_0_0;
  localparam logic [9:0] EXP_ERR      = 10'b0000_0001_0_1;
  localparam logic [9:0] EXP_REDIRECT = 10'b1111_1110_1_0;
  localparam logic [9:0] EXP_STALL    = 10'b0011_0100_0_0;

  logic clk_i = 1'b0;
  logic rst_n;
  logic err_o;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: number of consecutive frozen cycles so far, and the sticky error.
  int frozenRun = 0;
  bit modelErr  = 1'b0;

  always #5 clk_i = ~clk_i;

  pipe_hazard_ctrl_if hz();

  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk_i(clk_i),
    .rst_n(rst_n),
    .hzd  (hz),
    .err_o(err_o)
  );

  task automatic checkOutput(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
  endtask

  function automatic logic [9:0] observedVec();
    return {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.ex_mem_write,
            hz.if_id_flush, hz.id_ex_flush, hz.ex_mem_flush, hz.mem_wb_flush,
            hz.pc_sel_redirect, err_o};
  endfunction

  // Once a wait has begun only dmem_ready ends it; otherwise an unready access starts one.
  function automatic bit modelFrozen();
    if (frozenRun > 0) return !hz.dmem_ready;
    return hz.mem_access && !hz.dmem_ready;
  endfunction

  function automatic logic [9:0] modelExpect();
    bit lu;
    if (modelErr) return EXP_ERR;
    if (modelFrozen()) return EXP_FREEZE;
    if (hz.mem_redirect) return EXP_REDIRECT;
    lu = hz.ex_memread && (hz.ex_writereg != 5'd0) &&
         ((hz.ex_writereg == hz.id_rs) || (hz.id_uses_rt && (hz.ex_writereg == hz.id_rt)));
    if (lu) return EXP_STALL;
    return EXP_IDLE;
  endfunction

  task automatic driveIdle();
    hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
    hz.ex_memread = 1'b0; hz.ex_writereg = 5'd0;
    hz.mem_redirect = 1'b0; hz.mem_access = 1'b0; hz.dmem_ready = 1'b1;
  endtask

  // One clock: drive at the falling edge, check just after, then advance the model on the rising edge.
  task automatic applyStimulus(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                               input bit usesRt, input bit memRead, input logic [4:0] wr,
                               input bit redirect, input bit access, input bit ready);
    bit fr;
    hz.id_rs = rs; hz.id_rt = rt; hz.id_uses_rt = usesRt;
    hz.ex_memread = memRead; hz.ex_writereg = wr;
    hz.mem_redirect = redirect; hz.mem_access = access; hz.dmem_ready = ready;
    #1;
    checkOutput(tag, observedVec(), modelExpect());
    fr = modelFrozen();
    @(posedge clk_i);
    if (!modelErr) begin
      if (fr) begin
        frozenRun++;
        if (frozenRun == TIMEOUT_TB + 1) modelErr = 1'b1;
      end else begin
        frozenRun = 0;
      end
    end
    @(negedge clk_i);
  endtask

  task automatic applyReset(input string tag);
    driveIdle();
    rst_n = 1'b0;
    #1;
    checkOutput(tag, observedVec(), EXP_IDLE);
    frozenRun = 0;
    modelErr  = 1'b0;
    @(negedge clk_i);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    driveIdle();
    @(negedge clk_i);
    applyReset("reset_idle");

    // Load-use on rs, then the bubble reaches EX and flow resumes.
    applyStimulus("loaduse_rs",    5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    applyStimulus("loaduse_after", 5'd8, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("loaduse_zero",  5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("loaduse_rt",    5'd3, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);
    applyStimulus("loaduse_rt_nu", 5'd3, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1);

    applyStimulus("redirect",       5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
    applyStimulus("redirect_after", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
    applyStimulus("redirect_vs_lu", 5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);

    // Ready three cycles late: exactly three frozen cycles.
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("wait3_c%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyStimulus("wait3_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
    applyStimulus("wait3_run",     5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Wait and redirect together: freeze first, redirect when ready arrives.
    for (int i = 0; i < 2; i++)
      applyStimulus($sformatf("wait_redir_c%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    applyStimulus("wait_redir_release", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);

    // Timeout: TIMEOUT+1 frozen cycles, then a sticky error.
    for (int i = 0; i < TIMEOUT_TB + 1; i++)
      applyStimulus($sformatf("timeout_c%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("err_hold_c%0d", i), 5'd1, 5'd2, 1'b1, 1'b1, 5'd1, 1'b1, 1'b0, 1'b1);
    applyReset("err_reset");
    applyStimulus("after_err_reset", 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);

    // Reset mid-wait must clear the counter: a fresh wait needs the full budget again.
    for (int i = 0; i < 3; i++)
      applyStimulus($sformatf("midwait_c%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyReset("midwait_reset");
    for (int i = 0; i < TIMEOUT_TB + 2; i++)
      applyStimulus($sformatf("rewait_c%0d", i), 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    applyReset("rewait_reset");

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        applyReset("rand_reset");
      end else begin
        applyStimulus("random",
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                      $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 9) < 7);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
